// File: rtl/pong_score_counter_pkg.sv
// rtl/pong_score_counter_pkg.sv - shared state encodings, defaults and BCD helper for the pong score counter
package pong_score_counter_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_WIN_L = 2'd1,
    ST_WIN_R = 2'd2
  } state_e;

  localparam int DEFAULT_WIN_SCORE = 11;

  // A digit enable low means the segment driver keeps every segment dark.
  localparam logic DIGIT_OFF = 1'b0;
  localparam logic DIGIT_ON  = 1'b1;

  // Two-digit BCD increment, holding at 99.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (tens == 4'd9 && ones == 4'd9) begin
      return {tens, ones};
    end
    if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - saturating two-digit BCD counter with synchronous clear
module bcd2_counter
  import pong_score_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'h00;
    end else if (inc) begin
      cnt_d = bcd_inc(cnt_q[7:4], cnt_q[3:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tens = cnt_q[7:4];
  assign ones = cnt_q[3:0];

endmodule

// File: rtl/pong_score_counter.sv
// rtl/pong_score_counter.sv - pong score keeping, win detection and winner-digit blinking
module pong_score_counter
  import pong_score_counter_pkg::*;
#(
  parameter int WIN_SCORE = DEFAULT_WIN_SCORE,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       new_game,
  output logic [3:0] left_tens,
  output logic [3:0] left_ones,
  output logic [3:0] right_tens,
  output logic [3:0] right_ones,
  output logic [3:0] digit_en,
  output logic       game_over,
  output logic       winner
);

  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_q, blink_d;
  logic            in_play, inc_left, inc_right, left_hit, right_hit;
  logic            lt_on, lo_on, rt_on, ro_on;

  // Simultaneous pulses are a void rally; new_game beats any pulse.
  assign in_play   = (state_q == ST_PLAY);
  assign inc_left  = in_play & point_left & ~point_right & ~new_game;
  assign inc_right = in_play & point_right & ~point_left & ~new_game;
  assign left_hit  = inc_left & (bcd_inc(left_tens, left_ones) == WIN_BCD);
  assign right_hit = inc_right & (bcd_inc(right_tens, right_ones) == WIN_BCD);

  bcd2_counter u_left (
    .clk  (clk),
    .rst  (rst),
    .clr  (new_game),
    .inc  (inc_left),
    .tens (left_tens),
    .ones (left_ones)
  );

  bcd2_counter u_right (
    .clk  (clk),
    .rst  (rst),
    .clr  (new_game),
    .inc  (inc_right),
    .tens (right_tens),
    .ones (right_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (left_hit) begin
            state_d = ST_WIN_L;
          end else if (right_hit) begin
            state_d = ST_WIN_R;
          end
        end
        ST_WIN_L, ST_WIN_R: state_d = state_q;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  // Divider idles cleared and lit in PLAY so every win starts with a full lit half-period.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (new_game || in_play) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CW'(1);
    end
  end

  always_comb begin
    game_over = (state_q != ST_PLAY);
    winner    = (state_q == ST_WIN_R);
    lt_on     = (left_tens != 4'd0) ? DIGIT_ON : DIGIT_OFF;
    lo_on     = DIGIT_ON;
    rt_on     = (right_tens != 4'd0) ? DIGIT_ON : DIGIT_OFF;
    ro_on     = DIGIT_ON;
    if (state_q == ST_WIN_L && !blink_q) begin
      lt_on = DIGIT_OFF;
      lo_on = DIGIT_OFF;
    end
    if (state_q == ST_WIN_R && !blink_q) begin
      rt_on = DIGIT_OFF;
      ro_on = DIGIT_OFF;
    end
    digit_en = {lt_on, lo_on, rt_on, ro_on};
  end

endmodule

// File: tb/tb_pong_score_counter.sv
// tb/tb_pong_score_counter.sv - self-checking bench for pong_score_counter
module tb_pong_score_counter;

  localparam int WIN = 11;
  localparam int BD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       point_left = 1'b0;
  logic       point_right = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] left_tens, left_ones, right_tens, right_ones, digit_en;
  logic       game_over, winner;
  logic [21:0] dut_v;

  int checks = 0;
  int failures = 0;

  int m_l, m_r, m_since;
  bit m_over, m_win;

  typedef struct {
    bit          pl;
    bit          pr;
    bit          ng;
    logic [21:0] exp;
  } vec_t;

  vec_t tab[6];

  pong_score_counter #(.WIN_SCORE(WIN), .BLINK_DIV(BD)) dut (
    .clk         (clk),
    .rst         (rst),
    .point_left  (point_left),
    .point_right (point_right),
    .new_game    (new_game),
    .left_tens   (left_tens),
    .left_ones   (left_ones),
    .right_tens  (right_tens),
    .right_ones  (right_ones),
    .digit_en    (digit_en),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  assign dut_v = {left_tens, left_ones, right_tens, right_ones, digit_en, game_over, winner};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_l = 0; m_r = 0; m_since = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_step(input bit pl, input bit pr, input bit ng);
    if (ng) begin
      model_reset();
    end else if (!m_over) begin
      if (pl && !pr) begin
        if (m_l < 99) m_l++;
        if (m_l == WIN) begin m_over = 1; m_win = 0; m_since = 0; end
      end else if (pr && !pl) begin
        if (m_r < 99) m_r++;
        if (m_r == WIN) begin m_over = 1; m_win = 1; m_since = 0; end
      end
    end else begin
      m_since++;
    end
  endtask

  function automatic logic [21:0] model_out();
    bit lit, lte, loe, rte, roe;
    lit = ((m_since / BD) % 2) == 0;
    lte = (m_l >= 10); loe = 1'b1;
    rte = (m_r >= 10); roe = 1'b1;
    if (m_over && !m_win && !lit) begin lte = 0; loe = 0; end
    if (m_over && m_win && !lit) begin rte = 0; roe = 0; end
    return {4'(m_l / 10), 4'(m_l % 10), 4'(m_r / 10), 4'(m_r % 10),
            lte, loe, rte, roe, m_over, m_win};
  endfunction

  task automatic step(input bit pl, input bit pr, input bit ng);
    point_left = pl; point_right = pr; new_game = ng;
    @(posedge clk);
    #1;
    model_step(pl, pr, ng);
    check("model", 32'(dut_v), 32'(model_out()));
  endtask

  initial begin
    tab[0] = '{1'b1, 1'b0, 1'b0, {4'd0, 4'd1, 4'd0, 4'd0, 4'b0101, 1'b0, 1'b0}};
    tab[1] = '{1'b0, 1'b1, 1'b0, {4'd0, 4'd1, 4'd0, 4'd1, 4'b0101, 1'b0, 1'b0}};
    tab[2] = '{1'b1, 1'b1, 1'b0, {4'd0, 4'd1, 4'd0, 4'd1, 4'b0101, 1'b0, 1'b0}};
    tab[3] = '{1'b0, 1'b0, 1'b0, {4'd0, 4'd1, 4'd0, 4'd1, 4'b0101, 1'b0, 1'b0}};
    tab[4] = '{1'b1, 1'b0, 1'b1, {4'd0, 4'd0, 4'd0, 4'd0, 4'b0101, 1'b0, 1'b0}};
    tab[5] = '{1'b0, 1'b1, 1'b0, {4'd0, 4'd0, 4'd0, 4'd1, 4'b0101, 1'b0, 1'b0}};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_v), 32'({16'h0000, 4'b0101, 2'b00}));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(tab[i].pl, tab[i].pr, tab[i].ng);
      check($sformatf("vec%0d", i), 32'(dut_v), 32'(tab[i].exp));
    end

    step(0, 0, 1);
    repeat (10) step(1, 0, 0);
    check("left10", 32'({left_tens, left_ones, digit_en}), 32'({4'd1, 4'd0, 4'b1101}));

    step(0, 0, 1);
    repeat (3) step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(1, 1, 0);
    check("void33", 32'({left_tens, left_ones, right_tens, right_ones}), 32'(16'h0303));

    repeat (7) step(0, 1, 0);
    check("right10_playing", 32'({right_tens, right_ones, game_over}), 32'({4'd1, 4'd0, 1'b0}));
    step(0, 1, 0);
    check("win_r", 32'({right_tens, right_ones, game_over, winner, digit_en}),
          32'({4'd1, 4'd1, 1'b1, 1'b1, 4'b0111}));

    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 0);
      check("blink", 32'(digit_en[1:0]), ((k / BD) % 2 == 0) ? 32'd3 : 32'd0);
      check("loser_static", 32'(digit_en[3:2]), 32'd1);
      check("frozen", 32'({right_tens, right_ones}), 32'(8'h11));
    end

    step(1, 0, 1);
    check("new_game", 32'({dut_v}), 32'({16'h0000, 4'b0101, 2'b00}));

    repeat (3) step(1, 0, 0);
    point_left = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst", 32'(dut_v), 32'({16'h0000, 4'b0101, 2'b00}));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 35 || r >= 90, r >= 35 && r < 80 || r >= 90, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
